// File: rtl/bcd_gray_pkg.sv
// Shared types and constants for the BCD/Gray checker: FSM states, digit limits, Gray decode helper.
// Pure declarations; no latency, no flow control.
package bcd_gray_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] GRAY_NINE = 4'b1101;

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_gray_checker_if.sv
// Handshake bus between the Gray producer, the checker and the next stage; parity pins exist only with GRAY_PARITY_EN.
// master = bench/producer side, slave = checker side.
interface bcd_gray_checker_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           gray_in;
  logic                 sync_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           bcd_out;
  logic                 range_err;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           state_out;
`ifdef GRAY_PARITY_EN
  logic                 parity_in;
  logic                 parity_out;
`endif

  modport master (
    output in_valid, gray_in, sync_clr, out_ready,
    input  in_ready, out_valid, bcd_out, range_err, step_err, err_count, state_out
`ifdef GRAY_PARITY_EN
    , output parity_in
    , input  parity_out
`endif
  );

  modport slave (
    input  in_valid, gray_in, sync_clr, out_ready,
    output in_ready, out_valid, bcd_out, range_err, step_err, err_count, state_out
`ifdef GRAY_PARITY_EN
    , input  parity_in
    , output parity_out
`endif
  );

endinterface

// File: rtl/gray2bin_dec.sv
// Combinational 4-bit Gray to binary decoder, MSB first.
// Zero latency; no flow control.
module gray2bin_dec (
  input  logic [3:0] gray,
  output logic [3:0] bin
);

  assign bin[3] = gray[3];
  assign bin[2] = bin[3] ^ gray[2];
  assign bin[1] = bin[2] ^ gray[1];
  assign bin[0] = bin[1] ^ gray[0];

endmodule

// File: rtl/bcd_gray_checker.sv
// Registers Gray words, decodes to BCD, flags range/step errors, counts them; GRAY_PARITY_EN adds parity pins.
// Latency 1 cycle; in_ready = (!out_valid || out_ready) && !sync_clr, outputs hold while stalled.
module bcd_gray_checker
  import bcd_gray_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter bit WRAP_OK   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_gray_checker_if.slave bus
);

  logic [3:0]           bin;
  logic [3:0]           prev_q;
  logic [3:0]           diff;
  state_t               state_q;
  logic                 out_valid_q;
  logic [3:0]           bcd_q;
  logic                 range_q;
  logic                 step_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic                 in_ready;
  logic                 accept;
  logic                 single_step;
  logic                 wrap_step;
  logic                 range_n;
  logic                 step_n;
  logic                 par_n;
  logic                 err_n;

  gray2bin_dec u_dec (
    .gray (bus.gray_in),
    .bin  (bin)
  );

  // sync_clr blocks the offered word so it is never half-consumed.
  assign in_ready = (!out_valid_q || bus.out_ready) && !bus.sync_clr;
  assign accept   = bus.in_valid && in_ready;

  assign diff        = bus.gray_in ^ prev_q;
  assign single_step = (diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0);
  assign wrap_step   = WRAP_OK && (prev_q == GRAY_NINE) && (bus.gray_in == 4'b0000);

  assign range_n = (bin > BCD_MAX);
  // In SYNC there is no history, so no step can be judged.
  assign step_n  = (state_q != SYNC) && !(single_step || wrap_step);

`ifdef GRAY_PARITY_EN
  logic par_q;
  // parity_in makes {gray_in, parity_in} odd.
  assign par_n = ~(^{bus.gray_in, bus.parity_in});
  assign bus.parity_out = par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_q <= 1'b0;
    else if (accept) par_q <= ^bin;
  end
`else
  assign par_n = 1'b0;
`endif

  assign err_n = range_n || step_n || par_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bcd_q       <= 4'd0;
      range_q     <= 1'b0;
      step_q      <= 1'b0;
      prev_q      <= 4'd0;
      cnt_q       <= '0;
      state_q     <= SYNC;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        bcd_q       <= bin;
        range_q     <= range_n;
        step_q      <= step_n;
        prev_q      <= bus.gray_in;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (bus.sync_clr) begin
        state_q <= SYNC;
        cnt_q   <= '0;
      end else if (accept) begin
        if (err_n)                 state_q <= FAULT;
        else if (state_q == SYNC)  state_q <= TRACK;
        if (err_n && (cnt_q != '1)) cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.range_err = range_q;
  assign bus.step_err  = step_q;
  assign bus.err_count = cnt_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_bcd_gray_checker.sv
// Scoreboard bench: u0 uses defaults (wrap legal, 8-bit counter), u1 has wrap illegal and a 2-bit counter.
// Expected outputs are hand-computed per directed vector and queued at issue time.
module tb_bcd_gray_checker;

  typedef struct packed {
    logic [3:0] bcd;
    logic       rng;
    logic       stp;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];

  bcd_gray_checker_if #(.ERR_CNT_W(8)) b0 ();
  bcd_gray_checker_if #(.ERR_CNT_W(2)) b1 ();

  bcd_gray_checker #(.ERR_CNT_W(8), .WRAP_OK(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  bcd_gray_checker #(.ERR_CNT_W(2), .WRAP_OK(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input logic [3:0] bcd, input logic rng, input logic stp,
                             input logic [7:0] cnt, input logic [1:0] st);
    exp_t e;
    e.bcd = bcd; e.rng = rng; e.stp = stp; e.cnt = cnt; e.st = st;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b0.out_valid && b0.out_ready) begin
        if (q0.size() == 0) chk("u0_unexpected_output", 1, 0);
        else begin
          e = q0.pop_front();
          chk("u0_bcd", b0.bcd_out, e.bcd);
          chk("u0_range", b0.range_err, e.rng);
          chk("u0_step", b0.step_err, e.stp);
          chk("u0_cnt", b0.err_count, e.cnt);
          chk("u0_state", b0.state_out, e.st);
        end
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("u1_unexpected_output", 1, 0);
        else begin
          e = q1.pop_front();
          chk("u1_bcd", b1.bcd_out, e.bcd);
          chk("u1_range", b1.range_err, e.rng);
          chk("u1_step", b1.step_err, e.stp);
          chk("u1_cnt", {6'd0, b1.err_count}, e.cnt);
          chk("u1_state", b1.state_out, e.st);
        end
      end
    end
  endtask

  // Drives one word and waits (bounded) for the edge that accepts it.
  task automatic send(input int d, input logic [3:0] g, input bit push, input exp_t e);
    logic acc;
    bit   ok;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (d == 0) begin b0.in_valid = 1'b1; b0.gray_in = g; end
    else        begin b1.in_valid = 1'b1; b1.gray_in = g; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      acc = (d == 0) ? b0.in_ready : b1.in_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    chk("accept_within_budget", {31'd0, ok}, 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dec_g [11];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    b0.in_valid = 1'b0; b0.gray_in = 4'd0; b0.sync_clr = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.gray_in = 4'd0; b1.sync_clr = 1'b0; b1.out_ready = 1'b1;
    dec_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b0000};

    #12;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_bcd", b0.bcd_out, 0);
    chk("rst_range", b0.range_err, 0);
    chk("rst_step", b0.step_err, 0);
    chk("rst_cnt", b0.err_count, 0);
    chk("rst_state", b0.state_out, 0);
    chk("rst_in_ready", b0.in_ready, 1);

    fork
      monitor();
    join_none

    cycle();
    rst_n = 1'b1;

    // Full decade plus the 9->0 wrap on u0 (wrap legal).
    for (int i = 0; i < 11; i++) begin
      send(0, dec_g[i], 1'b1, E((i == 10) ? 4'd0 : 4'(i), 1'b0, 1'b0, 8'd0, 2'd1));
    end

    // Distance-2 step: 0001 -> 0111.
    send(0, 4'b0001, 1'b1, E(4'd1, 1'b0, 1'b0, 8'd0, 2'd1));
    send(0, 4'b0111, 1'b1, E(4'd5, 1'b0, 1'b1, 8'd1, 2'd2));

    // sync_clr wins over an offered word.
    b0.sync_clr = 1'b1; b0.in_valid = 1'b1; b0.gray_in = 4'b0000;
    @(negedge clk);
    chk("sync_in_ready", b0.in_ready, 0);
    cycle();
    b0.sync_clr = 1'b0; b0.in_valid = 1'b0;
    chk("sync_state", b0.state_out, 0);
    chk("sync_cnt", b0.err_count, 0);
    chk("sync_out_valid", b0.out_valid, 0);

    // Out-of-range word, then repeated.
    send(0, 4'b1010, 1'b1, E(4'd12, 1'b1, 1'b0, 8'd1, 2'd2));
    send(0, 4'b1010, 1'b1, E(4'd12, 1'b1, 1'b1, 8'd2, 2'd2));

    b0.sync_clr = 1'b1;
    cycle();
    b0.sync_clr = 1'b0;

    // Backpressure: A accepted, B stalls three cycles, then both drain in order.
    b0.out_ready = 1'b0;
    send(0, 4'b0110, 1'b1, E(4'd4, 1'b0, 1'b0, 8'd0, 2'd1));
    b0.in_valid = 1'b1; b0.gray_in = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", b0.in_ready, 0);
      chk("bp_bcd_hold", b0.bcd_out, 4);
      chk("bp_out_valid", b0.out_valid, 1);
      cycle();
    end
    b0.out_ready = 1'b1;
    send(0, 4'b0111, 1'b1, E(4'd5, 1'b0, 1'b0, 8'd0, 2'd1));
    send(0, 4'b0101, 1'b1, E(4'd6, 1'b0, 1'b0, 8'd0, 2'd1));
    send(0, 4'b0101, 1'b1, E(4'd6, 1'b0, 1'b1, 8'd1, 2'd2));
    cycle();

    // u1: wrap is a step error, then repeats saturate a 2-bit counter.
    for (int i = 0; i < 10; i++) begin
      send(1, dec_g[i], 1'b1, E(4'(i), 1'b0, 1'b0, 8'd0, 2'd1));
    end
    send(1, 4'b0000, 1'b1, E(4'd0, 1'b0, 1'b1, 8'd1, 2'd2));
    send(1, 4'b0000, 1'b1, E(4'd0, 1'b0, 1'b1, 8'd2, 2'd2));
    send(1, 4'b0000, 1'b1, E(4'd0, 1'b0, 1'b1, 8'd3, 2'd2));
    send(1, 4'b0000, 1'b1, E(4'd0, 1'b0, 1'b1, 8'd3, 2'd2));
    send(1, 4'b0000, 1'b1, E(4'd0, 1'b0, 1'b1, 8'd3, 2'd2));
    cycle();

    // Reset with an output pending on u0: it must be discarded.
    b0.out_ready = 1'b0;
    send(0, 4'b0100, 1'b0, E(4'd0, 1'b0, 1'b0, 8'd0, 2'd0));
    @(negedge clk);
    chk("pre_rst_out_valid", b0.out_valid, 1);
    chk("pre_rst_bcd", b0.bcd_out, 7);
    chk("pre_rst_cnt", b0.err_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", b0.out_valid, 0);
    chk("midrst_bcd", b0.bcd_out, 0);
    chk("midrst_range", b0.range_err, 0);
    chk("midrst_step", b0.step_err, 0);
    chk("midrst_cnt", b0.err_count, 0);
    chk("midrst_state", b0.state_out, 0);
    chk("midrst_u1_cnt", {30'd0, b1.err_count}, 0);
    chk("midrst_u1_state", b1.state_out, 0);
    cycle();
    rst_n = 1'b1;
    b0.out_ready = 1'b1;

    repeat (3) cycle();
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
